// File: rtl/udp_chk_pkg.sv
// Shared types and widths for the UDP truth-table checker.
package udp_chk_pkg;

    localparam int unsigned VEC_W    = 2;
    localparam int unsigned ERR_W    = 3;
    localparam int unsigned NUM_VECS = 4;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/udp_truth_checker.sv
// Walks a 2-input UDP through all four input vectors, waits a settle time for each,
// and scores its output against an expected truth table.
module udp_truth_checker
    import udp_chk_pkg::*;
#(
    parameter logic [NUM_VECS-1:0] TRUTH_TABLE   = 4'b0110,
    parameter int unsigned         SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_out,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_err_vec
);

    state_t             state, state_n;
    logic [VEC_W-1:0]   vec, vec_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               a_n, b_n, busy_n, done_n;
    logic [ERR_W-1:0]   err_n;
    logic [VEC_W-1:0]   first_n;
    logic               mismatch_c;

    // X/Z on the UDP output must score as a failure, hence the case inequality.
    assign mismatch_c = (dut_out !== TRUTH_TABLE[vec]);
    assign pass       = done && (err_count == ERR_W'(0));

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        vec_n   = vec;
        cnt_n   = cnt;
        a_n     = a;
        b_n     = b;
        busy_n  = busy;
        done_n  = done;
        err_n   = err_count;
        first_n = first_err_vec;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SETTLE;
                    vec_n   = VEC_W'(0);
                    cnt_n   = CNT_W'(0);
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    err_n   = ERR_W'(0);
                    first_n = VEC_W'(0);
                end
            end
            SETTLE: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    err_n = err_count + ERR_W'(1);
                    if (err_count == ERR_W'(0)) begin
                        first_n = vec;
                    end
                end
                if (vec == VEC_W'(NUM_VECS - 1)) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n    = SETTLE;
                    vec_n      = vec + VEC_W'(1);
                    {a_n, b_n} = vec + VEC_W'(1);
                    cnt_n      = CNT_W'(0);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            vec           <= VEC_W'(0);
            cnt           <= CNT_W'(0);
            a             <= 1'b0;
            b             <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_count     <= ERR_W'(0);
            first_err_vec <= VEC_W'(0);
        end else begin
            state         <= state_n;
            vec           <= vec_n;
            cnt           <= cnt_n;
            a             <= a_n;
            b             <= b_n;
            busy          <= busy_n;
            done          <= done_n;
            err_count     <= err_n;
            first_err_vec <= first_n;
        end
    end

endmodule
